// File: rtl/rggen_apb_initiator_if.sv
// Command, response and APB signal bundle for rggen_apb_initiator.
// The master modport is the initiator's view; slave is the environment driving it.
interface rggen_apb_initiator_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      i_cmd_valid;
  logic                      o_cmd_ready;
  logic [ADDRESS_WIDTH-1:0]  i_cmd_address;
  logic                      i_cmd_write;
  logic [DATA_WIDTH-1:0]     i_cmd_write_data;
  logic [DATA_WIDTH/8-1:0]   i_cmd_strobe;
  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic [DATA_WIDTH-1:0]     o_rsp_read_data;
  logic                      o_rsp_error;
  logic                      o_psel;
  logic                      o_penable;
  logic                      o_pwrite;
  logic [ADDRESS_WIDTH-1:0]  o_paddr;
  logic [DATA_WIDTH-1:0]     o_pwdata;
  logic [DATA_WIDTH/8-1:0]   o_pstrb;
  logic                      i_pready;
  logic                      i_pslverr;
  logic [DATA_WIDTH-1:0]     i_prdata;

  modport master (
    input  i_cmd_valid, i_cmd_address, i_cmd_write, i_cmd_write_data, i_cmd_strobe,
    output o_cmd_ready,
    output o_rsp_valid, o_rsp_read_data, o_rsp_error,
    input  i_rsp_ready,
    output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb,
    input  i_pready, i_pslverr, i_prdata
  );

  modport slave (
    output i_cmd_valid, i_cmd_address, i_cmd_write, i_cmd_write_data, i_cmd_strobe,
    input  o_cmd_ready,
    input  o_rsp_valid, o_rsp_read_data, o_rsp_error,
    output i_rsp_ready,
    input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb,
    output i_pready, i_pslverr, i_prdata
  );
endinterface

// File: rtl/rggen_apb_initiator.sv
// Single-outstanding APB initiator: valid/ready command in, one APB transfer,
// completion parked in a one-entry response buffer until consumed.
module rggen_apb_initiator #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input logic                  clk,
  input logic                  rst,
  rggen_apb_initiator_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] paddr_reg, paddr_next;
  logic                     pwrite_reg, pwrite_next;
  logic [DATA_WIDTH-1:0]    pwdata_reg, pwdata_next;
  logic [STRB_WIDTH-1:0]    pstrb_reg, pstrb_next;
  logic                     rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0]    rsp_data_reg, rsp_data_next;
  logic                     rsp_error_reg, rsp_error_next;

  logic [ADDRESS_WIDTH-1:0] aligned_addr;
  logic                     cmd_ready;
  logic                     cmd_fire;
  logic                     complete;

  // Byte address is word-aligned to the bus width before it reaches PADDR.
  for (genvar gi = 0; gi < ADDRESS_WIDTH; gi++) begin : g_align
    if (gi < ADDR_LSB) begin : g_low
      assign aligned_addr[gi] = 1'b0;
    end else begin : g_keep
      assign aligned_addr[gi] = bus.i_cmd_address[gi];
    end
  end

  // Ready also looks at i_rsp_ready so a draining response frees the slot in the same cycle.
  assign cmd_ready = (state_reg == IDLE) && (!rsp_valid_reg || bus.i_rsp_ready) && !rst;
  assign cmd_fire  = bus.i_cmd_valid && cmd_ready;
  assign complete  = (state_reg == ACCESS) && bus.i_pready;

  always_comb begin
    state_next     = state_reg;
    paddr_next     = paddr_reg;
    pwrite_next    = pwrite_reg;
    pwdata_next    = pwdata_reg;
    pstrb_next     = pstrb_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_error_next = rsp_error_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          state_next  = SETUP;
          paddr_next  = aligned_addr;
          pwrite_next = bus.i_cmd_write;
          pwdata_next = bus.i_cmd_write_data;
          pstrb_next  = bus.i_cmd_write ? bus.i_cmd_strobe : '0;
        end
      end
      SETUP:   state_next = ACCESS;
      ACCESS:  if (bus.i_pready) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Completion and consumption never coincide: completion implies the buffer was empty.
    if (complete) begin
      rsp_valid_next = 1'b1;
      rsp_error_next = bus.i_pslverr;
      rsp_data_next  = (!pwrite_reg && !bus.i_pslverr) ? bus.i_prdata : '0;
    end else if (rsp_valid_reg && bus.i_rsp_ready) begin
      rsp_valid_next = 1'b0;
      rsp_error_next = 1'b0;
      rsp_data_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      paddr_reg     <= '0;
      pwrite_reg    <= 1'b0;
      pwdata_reg    <= '0;
      pstrb_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      paddr_reg     <= paddr_next;
      pwrite_reg    <= pwrite_next;
      pwdata_reg    <= pwdata_next;
      pstrb_reg     <= pstrb_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_error_reg <= rsp_error_next;
    end
  end

  assign bus.o_cmd_ready     = cmd_ready;
  assign bus.o_psel          = (state_reg != IDLE);
  assign bus.o_penable       = (state_reg == ACCESS);
  assign bus.o_pwrite        = pwrite_reg;
  assign bus.o_paddr         = paddr_reg;
  assign bus.o_pwdata        = pwdata_reg;
  assign bus.o_pstrb         = pstrb_reg;
  assign bus.o_rsp_valid     = rsp_valid_reg;
  assign bus.o_rsp_read_data = rsp_data_reg;
  assign bus.o_rsp_error     = rsp_error_reg;
endmodule

// File: tb/tb_rggen_apb_initiator.sv
// Bench for rggen_apb_initiator: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level model with a word memory completer.
module tb_rggen_apb_initiator;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rggen_apb_initiator_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rggen_apb_initiator #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total;
  int bad;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;
    logic          err;
    logic          pulse;
    logic [DW-1:0] prdata;
    logic [AW-1:0] exp_paddr;
    logic [SW-1:0] exp_pstrb;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } cmd_t;

  vec_t          vecs[6];
  logic [DW-1:0] mem[64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
    bus.i_cmd_valid      = 1'b1;
    bus.i_cmd_write      = wr;
    bus.i_cmd_address    = a;
    bus.i_cmd_write_data = d;
    bus.i_cmd_strobe     = s;
  endtask

  // One complete transfer from an idle, empty initiator; checks every cycle of the timeline.
  task automatic run_vec(input int idx, input vec_t v);
    drive_cmd(v.write, v.addr, v.wdata, v.strb);
    bus.i_rsp_ready = 1'b0;
    bus.i_pready    = 1'b0;
    bus.i_pslverr   = 1'b0;
    #1;
    chk("vec_cmd_ready", 64'(bus.o_cmd_ready), 64'(1));
    step();
    bus.i_cmd_valid = 1'b0;
    chk("vec_setup_psel", 64'(bus.o_psel), 64'(1));
    chk("vec_setup_penable", 64'(bus.o_penable), 64'(0));
    chk("vec_setup_paddr", 64'(bus.o_paddr), 64'(v.exp_paddr));
    chk("vec_setup_pwrite", 64'(bus.o_pwrite), 64'(v.write));
    chk("vec_setup_pwdata", 64'(bus.o_pwdata), 64'(v.wdata));
    chk("vec_setup_pstrb", 64'(bus.o_pstrb), 64'(v.exp_pstrb));
    for (int w = 0; w <= v.waits; w++) begin
      step();
      chk("vec_access_psel", 64'(bus.o_psel), 64'(1));
      chk("vec_access_penable", 64'(bus.o_penable), 64'(1));
      chk("vec_access_paddr", 64'(bus.o_paddr), 64'(v.exp_paddr));
      chk("vec_access_pstrb", 64'(bus.o_pstrb), 64'(v.exp_pstrb));
      bus.i_pready  = (w == v.waits);
      bus.i_pslverr = (w == v.waits) ? v.err : v.pulse;
      bus.i_prdata  = (w == v.waits) ? v.prdata : ~v.prdata;
    end
    step();
    bus.i_pready  = 1'b0;
    bus.i_pslverr = 1'b0;
    chk("vec_rsp_valid", 64'(bus.o_rsp_valid), 64'(1));
    chk("vec_rsp_psel", 64'(bus.o_psel), 64'(0));
    chk("vec_rsp_data", 64'(bus.o_rsp_read_data), 64'(v.exp_rdata));
    chk("vec_rsp_error", 64'(bus.o_rsp_error), 64'(v.exp_err));
    #1;
    chk("vec_ready_blocked", 64'(bus.o_cmd_ready), 64'(0));
    bus.i_rsp_ready = 1'b1;
    #1;
    chk("vec_ready_drain", 64'(bus.o_cmd_ready), 64'(1));
    step();
    bus.i_rsp_ready = 1'b0;
    chk("vec_rsp_cleared", 64'(bus.o_rsp_valid), 64'(0));
    $display("vec %0d: wr=%0b addr=%04h paddr=%04h rsp_data=%08h rsp_err=%0b",
             idx, v.write, v.addr, v.exp_paddr, v.exp_rdata, v.exp_err);
  endtask

  task automatic run_backpressure();
    logic [DW-1:0] held_data;
    drive_cmd(1'b1, 16'h0050, 32'h1111_1111, 4'hF);
    bus.i_rsp_ready = 1'b0;
    bus.i_pready    = 1'b0;
    #1;
    chk("bp_first_ready", 64'(bus.o_cmd_ready), 64'(1));
    step();
    drive_cmd(1'b0, 16'h0062, 32'h0, 4'hF);
    step();
    bus.i_pready = 1'b1;
    bus.i_prdata = 32'h7777_7777;
    step();
    bus.i_pready = 1'b0;
    held_data = bus.o_rsp_read_data;
    chk("bp_rsp_data", 64'(held_data), 64'(0));
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_cmd_ready", 64'(bus.o_cmd_ready), 64'(0));
      chk("bp_psel", 64'(bus.o_psel), 64'(0));
      chk("bp_rsp_valid", 64'(bus.o_rsp_valid), 64'(1));
      chk("bp_rsp_hold", 64'(bus.o_rsp_read_data), 64'(held_data));
      chk("bp_rsp_err", 64'(bus.o_rsp_error), 64'(0));
      step();
    end
    bus.i_rsp_ready = 1'b1;
    #1;
    chk("bp_accept", 64'(bus.o_cmd_ready), 64'(1));
    step();
    bus.i_rsp_ready = 1'b0;
    bus.i_cmd_valid = 1'b0;
    chk("bp2_psel", 64'(bus.o_psel), 64'(1));
    chk("bp2_penable", 64'(bus.o_penable), 64'(0));
    chk("bp2_paddr", 64'(bus.o_paddr), 64'(16'h0060));
    chk("bp2_pwrite", 64'(bus.o_pwrite), 64'(0));
    chk("bp2_pstrb", 64'(bus.o_pstrb), 64'(0));
    chk("bp2_rsp_cleared", 64'(bus.o_rsp_valid), 64'(0));
    step();
    bus.i_pready = 1'b1;
    bus.i_prdata = 32'h0BAD_CAFE;
    step();
    bus.i_pready = 1'b0;
    chk("bp2_rsp_valid", 64'(bus.o_rsp_valid), 64'(1));
    chk("bp2_rsp_data", 64'(bus.o_rsp_read_data), 64'(32'h0BAD_CAFE));
    bus.i_rsp_ready = 1'b1;
    step();
    bus.i_rsp_ready = 1'b0;
    $display("backpressure: held response then accepted second command");
  endtask

  task automatic run_stream();
    logic [AW-1:0] q_addr[$];
    logic          q_wr[$];
    int            k;
    int            got;
    int            last;
    k = 0;
    got = 0;
    last = -1;
    bus.i_rsp_ready = 1'b1;
    bus.i_pready    = 1'b1;
    bus.i_pslverr   = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (k < 8) drive_cmd(k[0], 16'h0100 + 16'(k * 4) + 16'(k % 4), 32'h1000 + 32'(k), 4'hF);
      else bus.i_cmd_valid = 1'b0;
      bus.i_prdata = 32'hA5A5_0000 | {16'h0, bus.o_paddr};
      #1;
      if (bus.o_rsp_valid) begin
        chk("stream_rsp_expected", 64'(q_addr.size() > 0), 64'(1));
        if (q_addr.size() > 0) begin
          chk("stream_rsp_data", 64'(bus.o_rsp_read_data),
              64'(q_wr[0] ? 32'h0 : (32'hA5A5_0000 | {16'h0, q_addr[0]})));
          chk("stream_rsp_err", 64'(bus.o_rsp_error), 64'(0));
          $display("stream rsp %0d: wr=%0b paddr=%04h data=%08h", got, q_wr[0], q_addr[0],
                   bus.o_rsp_read_data);
          void'(q_addr.pop_front());
          void'(q_wr.pop_front());
        end
        got++;
      end
      if (bus.i_cmd_valid && bus.o_cmd_ready) begin
        if (last >= 0) chk("stream_gap", 64'(cyc - last), 64'(3));
        last = cyc;
        q_addr.push_back(bus.i_cmd_address & 16'hFFFC);
        q_wr.push_back(bus.i_cmd_write);
        k++;
      end
      step();
    end
    chk("stream_count", 64'(got), 64'(8));
    bus.i_cmd_valid = 1'b0;
    bus.i_rsp_ready = 1'b0;
    bus.i_pready    = 1'b0;
  endtask

  task automatic run_reset_mid();
    drive_cmd(1'b0, 16'h0044, 32'h0, 4'hF);
    bus.i_pready = 1'b0;
    step();
    bus.i_cmd_valid = 1'b0;
    step();
    chk("rstmid_in_access", 64'(bus.o_penable), 64'(1));
    rst = 1'b1;
    step();
    chk("rstmid_psel", 64'(bus.o_psel), 64'(0));
    chk("rstmid_penable", 64'(bus.o_penable), 64'(0));
    chk("rstmid_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
    chk("rstmid_paddr", 64'(bus.o_paddr), 64'(0));
    chk("rstmid_cmd_ready", 64'(bus.o_cmd_ready), 64'(0));
    rst = 1'b0;
    bus.i_pready = 1'b1;
    step();
    chk("rstmid_after_psel", 64'(bus.o_psel), 64'(0));
    chk("rstmid_after_rsp", 64'(bus.o_rsp_valid), 64'(0));
    bus.i_pready = 1'b0;
    $display("reset mid-access: transfer aborted");
    run_vec(100, vecs[1]);
  endtask

  // Model: age 0 = no transfer, 1 = setup cycle, >=2 = access cycles; one response slot.
  task automatic run_random(input int cycles);
    cmd_t          cur;
    cmd_t          fly;
    int            age;
    logic          pend;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    logic          take_new;
    logic          drain;
    logic          complete;
    logic          fire;
    int            n_cmd;
    int            n_rsp;
    int            idx;
    age = 0;
    pend = 1'b0;
    exp_data = '0;
    exp_err = 1'b0;
    take_new = 1'b1;
    n_cmd = 0;
    n_rsp = 0;
    fly = '{default: '0};
    cur = '{default: '0};
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int cyc = 0; cyc < cycles + 20; cyc++) begin
      drain = (cyc >= cycles);
      if (take_new) begin
        cur.addr  = 16'($urandom_range(0, 255));
        cur.write = 1'($urandom);
        cur.wdata = $urandom;
        cur.strb  = 4'($urandom);
        drive_cmd(cur.write, cur.addr, cur.wdata, cur.strb);
        bus.i_cmd_valid = ($urandom % 2) == 1;
      end
      if (drain) bus.i_cmd_valid = 1'b0;
      bus.i_rsp_ready = drain || (($urandom % 3) != 0);
      bus.i_pready    = drain || (($urandom % 2) == 1);
      bus.i_pslverr   = ($urandom % 6) == 0;
      idx = int'(fly.addr[7:2]);
      bus.i_prdata = (age >= 2 && !fly.write) ? mem[idx] : $urandom;
      #1;
      chk("rnd_cmd_ready", 64'(bus.o_cmd_ready), 64'((age == 0) && (!pend || bus.i_rsp_ready)));
      chk("rnd_psel", 64'(bus.o_psel), 64'(age != 0));
      chk("rnd_penable", 64'(bus.o_penable), 64'(age >= 2));
      if (age != 0) begin
        chk("rnd_paddr", 64'(bus.o_paddr), 64'(fly.addr - (fly.addr % 16'(SW))));
        chk("rnd_pwrite", 64'(bus.o_pwrite), 64'(fly.write));
        chk("rnd_pwdata", 64'(bus.o_pwdata), 64'(fly.wdata));
        chk("rnd_pstrb", 64'(bus.o_pstrb), 64'(fly.write ? fly.strb : 4'h0));
      end
      chk("rnd_rsp_valid", 64'(bus.o_rsp_valid), 64'(pend));
      if (pend) begin
        chk("rnd_rsp_data", 64'(bus.o_rsp_read_data), 64'(exp_data));
        chk("rnd_rsp_err", 64'(bus.o_rsp_error), 64'(exp_err));
      end
      complete = (age >= 2) && bus.i_pready;
      fire = bus.i_cmd_valid && (age == 0) && (!pend || bus.i_rsp_ready);
      if (pend && bus.i_rsp_ready) begin
        $display("rnd rsp %0d: data=%08h err=%0b", n_rsp, exp_data, exp_err);
        pend = 1'b0;
        n_rsp++;
      end
      if (complete) begin
        pend = 1'b1;
        exp_err = bus.i_pslverr;
        if (bus.i_pslverr) begin
          exp_data = '0;
        end else if (fly.write) begin
          exp_data = '0;
          for (int b = 0; b < SW; b++)
            if (fly.strb[b]) mem[idx][8*b +: 8] = fly.wdata[8*b +: 8];
        end else begin
          exp_data = mem[idx];
        end
        age = 0;
      end else if (age != 0) begin
        age++;
      end
      if (fire) begin
        fly = cur;
        age = 1;
        n_cmd++;
      end
      take_new = !bus.i_cmd_valid || fire;
      step();
    end
    chk("rnd_drained", 64'((age == 0) && !pend), 64'(1));
    chk("rnd_rsp_count", 64'(n_rsp), 64'(n_cmd));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    //         wr    addr      wdata         strb wt err pulse prdata        paddr     pstrb rdata          err
    vecs[0] = '{1'b1, 16'h0006, 32'hDEADBEEF, 4'hC, 0, 1'b0, 1'b0, 32'h5555_5555, 16'h0004, 4'hC, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 16'h0010, 32'h0,        4'hF, 3, 1'b0, 1'b0, 32'h1234_5678, 16'h0010, 4'h0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 16'h0023, 32'h0,        4'h0, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, 16'h0020, 4'h0, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 16'h0031, 32'h0000_AAAA, 4'h5, 1, 1'b0, 1'b1, 32'hCAFE_F00D, 16'h0030, 4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 16'hFFFF, 32'h0123_4567, 4'h3, 0, 1'b1, 1'b0, 32'h9999_9999, 16'hFFFC, 4'h3, 32'h0,         1'b1};
    vecs[5] = '{1'b1, 16'h1002, 32'h8765_4321, 4'h0, 1, 1'b0, 1'b0, 32'h4444_4444, 16'h1000, 4'h0, 32'h0,         1'b0};

    bus.i_cmd_valid      = 1'b1;
    bus.i_cmd_address    = 16'h1234;
    bus.i_cmd_write      = 1'b1;
    bus.i_cmd_write_data = 32'hFFFF_FFFF;
    bus.i_cmd_strobe     = 4'hF;
    bus.i_rsp_ready      = 1'b1;
    bus.i_pready         = 1'b0;
    bus.i_pslverr        = 1'b0;
    bus.i_prdata         = '0;
    rst = 1'b1;
    step();
    step();
    chk("reset_psel", 64'(bus.o_psel), 64'(0));
    chk("reset_penable", 64'(bus.o_penable), 64'(0));
    chk("reset_pwrite", 64'(bus.o_pwrite), 64'(0));
    chk("reset_paddr", 64'(bus.o_paddr), 64'(0));
    chk("reset_pwdata", 64'(bus.o_pwdata), 64'(0));
    chk("reset_pstrb", 64'(bus.o_pstrb), 64'(0));
    chk("reset_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
    chk("reset_rsp_data", 64'(bus.o_rsp_read_data), 64'(0));
    chk("reset_rsp_error", 64'(bus.o_rsp_error), 64'(0));
    chk("reset_cmd_ready", 64'(bus.o_cmd_ready), 64'(0));
    rst = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_rsp_ready = 1'b0;
    step();
    $display("reset: outputs cleared");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    run_backpressure();
    run_stream();
    run_reset_mid();
    run_random(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
